// File: rtl/rs_parity_enc.sv
// Streaming systematic Reed-Solomon encoder: K message bytes in, K data bytes plus 4 parity bytes out.
// Build option: define RS_ENC_PARITY_INVERT_EN to bitwise-invert every emitted parity byte.

module rs_parity_enc #(
   parameter int K = 28
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_par,
   output logic       o_last
);

`ifdef RS_ENC_PARITY_INVERT_EN
   localparam logic [7:0] PAR_MASK = 8'hFF;
`else
   localparam logic [7:0] PAR_MASK = 8'h00;
`endif

   localparam logic [7:0] LAST_IDX = 8'(K - 1);

   typedef enum logic [0:0] {
      DATA   = 1'b0,
      PARITY = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [3:0][7:0] rem;
   logic [3:0][7:0] rem_nx;
   logic [7:0]      cnt;
   logic [7:0]      cnt_nx;
   logic [1:0]      pcnt;
   logic [1:0]      pcnt_nx;
   logic            ready_nx;
   logic            valid_nx;
   logic            par_nx;
   logic            last_nx;
   logic [7:0]      data_nx;
   logic [7:0]      fb;

   // GF(256) multiply modulo x^8+x^4+x^3+x^2+1; constant b folds into an XOR network
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            acc = acc ^ x;
         end else begin
            acc = acc;
         end
         if (x[7]) begin
            x = {x[6:0], 1'b0} ^ 8'h1D;
         end else begin
            x = {x[6:0], 1'b0};
         end
      end
      return acc;
   endfunction

   assign fb = i_data ^ rem[3];

   // Next-state, remainder update and output decode
   always_comb begin
      state_nx = state;
      rem_nx   = rem;
      cnt_nx   = cnt;
      pcnt_nx  = pcnt;
      ready_nx = o_ready;
      valid_nx = 1'b0;
      par_nx   = 1'b0;
      last_nx  = 1'b0;
      data_nx  = o_data;

      case (state)
         DATA: begin
            ready_nx = 1'b1;
            if (i_valid) begin
               rem_nx[3] = rem[2] ^ gf_mul(fb, 8'h0F);
               rem_nx[2] = rem[1] ^ gf_mul(fb, 8'h36);
               rem_nx[1] = rem[0] ^ gf_mul(fb, 8'h78);
               rem_nx[0] = gf_mul(fb, 8'h40);
               data_nx   = i_data;
               valid_nx  = 1'b1;
               if (cnt == LAST_IDX) begin
                  state_nx = PARITY;
                  cnt_nx   = 8'h00;
                  pcnt_nx  = 2'd0;
                  ready_nx = 1'b0;
               end else begin
                  cnt_nx = cnt + 8'h01;
               end
            end else begin
               cnt_nx = cnt;
            end
         end
         PARITY: begin
            // Parity goes out high-order first, so the remainder simply shifts up
            data_nx  = rem[3] ^ PAR_MASK;
            valid_nx = 1'b1;
            par_nx   = 1'b1;
            rem_nx   = {rem[2:0], 8'h00};
            if (pcnt == 2'd3) begin
               last_nx  = 1'b1;
               ready_nx = 1'b1;
               state_nx = DATA;
               rem_nx   = {4{8'h00}};
               cnt_nx   = 8'h00;
               pcnt_nx  = 2'd0;
            end else begin
               ready_nx = 1'b0;
               pcnt_nx  = pcnt + 2'd1;
            end
         end
         default: begin
            state_nx = DATA;
            rem_nx   = {4{8'h00}};
            cnt_nx   = 8'h00;
            pcnt_nx  = 2'd0;
            ready_nx = 1'b1;
         end
      endcase
   end

   // State, remainder and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= DATA;
         rem     <= {4{8'h00}};
         cnt     <= 8'h00;
         pcnt    <= 2'd0;
         o_ready <= 1'b1;
         o_valid <= 1'b0;
         o_data  <= 8'h00;
         o_par   <= 1'b0;
         o_last  <= 1'b0;
      end else begin
         state   <= state_nx;
         rem     <= rem_nx;
         cnt     <= cnt_nx;
         pcnt    <= pcnt_nx;
         o_ready <= ready_nx;
         o_valid <= valid_nx;
         o_data  <= data_nx;
         o_par   <= par_nx;
         o_last  <= last_nx;
      end
   end

endmodule

// File: tb/tb_rs_parity_enc.sv
// Bench for rs_parity_enc: directed K=1 codeword plus randomized K=28 traffic checked
// against a table-driven GF(256) long-division model and decoder-style syndromes.

module tb_rs_parity_enc;

   localparam int K28 = 28;
`ifdef RS_ENC_PARITY_INVERT_EN
   localparam logic [7:0] PMASK = 8'hFF;
`else
   localparam logic [7:0] PMASK = 8'h00;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1, valid1, ready1, ovalid1, par1, last1;
   logic [7:0] data1, odata1;
   logic       rst28, valid28, ready28, ovalid28, par28, last28;
   logic [7:0] data28, odata28;

   rs_parity_enc #(.K(1)) u_k1 (
      .i_clk(clk), .i_rst(rst1), .i_valid(valid1), .i_data(data1),
      .o_ready(ready1), .o_valid(ovalid1), .o_data(odata1), .o_par(par1), .o_last(last1)
   );

   rs_parity_enc #(.K(K28)) u_k28 (
      .i_clk(clk), .i_rst(rst28), .i_valid(valid28), .i_data(data28),
      .o_ready(ready28), .o_valid(ovalid28), .o_data(odata28), .o_par(par28), .o_last(last28)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] alog [0:255];
   int         lg   [0:255];
   logic [7:0] gen_c [4];
   logic [7:0] k1_par [4];

   logic       exp_ready, exp_valid, exp_par, exp_last;
   logic [7:0] exp_data;
   logic [7:0] msg [$];
   logic [7:0] par_q [$];
   logic [7:0] cw [$];
   int         cw_done;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build_tables();
      int x;
      x = 1;
      for (int i = 0; i < 255; i++) begin
         alog[i] = 8'(x);
         lg[x]   = i;
         x = x << 1;
         if ((x & 32'h100) != 0) x = x ^ 32'h11D;
      end
      alog[255] = alog[0];
      lg[0]     = 0;
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return alog[(lg[a] + lg[b]) % 255];
   endfunction

   // m(x)*x^4 mod g(x) by textbook long division, highest-degree coefficient first
   task automatic ref_parity();
      logic [7:0] a [K28 + 4];
      logic [7:0] c;
      for (int i = 0; i < K28; i++) a[i] = msg[i];
      for (int i = K28; i < K28 + 4; i++) a[i] = 8'h00;
      for (int i = 0; i < K28; i++) begin
         c = a[i];
         for (int j = 1; j <= 4; j++) a[i + j] = a[i + j] ^ gmul(c, gen_c[j - 1]);
      end
      par_q.delete();
      for (int j = 0; j < 4; j++) par_q.push_back(a[K28 + j]);
   endtask

   // Evaluate the received codeword at a^0..a^3 as a decoder would
   task automatic check_syndromes();
      logic [7:0] s;
      for (int j = 0; j < 4; j++) begin
         s = 8'h00;
         foreach (cw[i]) s = gmul(s, alog[j]) ^ cw[i];
         check_eq($sformatf("syndrome_S%0d", j), {24'h0, s}, 32'h0);
      end
      check_eq("codeword_length", cw.size(), K28 + 4);
   endtask

   // Drive one cycle on the K=28 instance, advance the model, then compare
   task automatic step28(input logic rst, input logic vld, input logic [7:0] dat);
      rst28   = rst;
      valid28 = vld;
      data28  = dat;
      if (rst) begin
         msg.delete();
         par_q.delete();
         exp_ready = 1'b1;
         exp_valid = 1'b0;
         exp_data  = 8'h00;
         exp_par   = 1'b0;
         exp_last  = 1'b0;
      end else if (exp_ready) begin
         exp_par  = 1'b0;
         exp_last = 1'b0;
         if (vld) begin
            exp_valid = 1'b1;
            exp_data  = dat;
            msg.push_back(dat);
            if (msg.size() == K28) begin
               ref_parity();
               msg.delete();
               exp_ready = 1'b0;
            end
         end else begin
            exp_valid = 1'b0;
         end
      end else begin
         exp_data  = par_q.pop_front() ^ PMASK;
         exp_valid = 1'b1;
         exp_par   = 1'b1;
         exp_last  = (par_q.size() == 0);
         exp_ready = exp_last;
      end
      @(negedge clk);
      check_eq("k28_ready", ready28, exp_ready);
      check_eq("k28_valid", ovalid28, exp_valid);
      check_eq("k28_par", par28, exp_par);
      check_eq("k28_last", last28, exp_last);
      if (exp_valid || rst) check_eq("k28_data", odata28, exp_data);
      if (rst) begin
         cw.delete();
      end else if (exp_valid) begin
         cw.push_back(exp_par ? (odata28 ^ PMASK) : odata28);
         if (exp_last) begin
            check_syndromes();
            cw.delete();
            cw_done++;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard, lowcnt;
      logic found;

      rst1 = 1'b1; valid1 = 1'b0; data1 = 8'h00;
      rst28 = 1'b1; valid28 = 1'b0; data28 = 8'h00;
      build_tables();
      gen_c[0] = 8'h0F; gen_c[1] = 8'h36; gen_c[2] = 8'h78; gen_c[3] = 8'h40;
      k1_par[0] = 8'h0F; k1_par[1] = 8'h36; k1_par[2] = 8'h78; k1_par[3] = 8'h40;

      // K=1: single byte 0x01, junk input while not ready must be ignored
      @(negedge clk);
      @(negedge clk);
      check_eq("k1_rst_ready", ready1, 1'b1);
      check_eq("k1_rst_valid", ovalid1, 1'b0);
      check_eq("k1_rst_data", odata1, 8'h00);
      check_eq("k1_rst_par", par1, 1'b0);
      check_eq("k1_rst_last", last1, 1'b0);
      rst1 = 1'b0; valid1 = 1'b1; data1 = 8'h01;
      @(negedge clk);
      check_eq("k1_data_valid", ovalid1, 1'b1);
      check_eq("k1_data_byte", odata1, 8'h01);
      check_eq("k1_data_par", par1, 1'b0);
      check_eq("k1_data_ready", ready1, 1'b0);
      data1 = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq($sformatf("k1_par%0d_byte", i), odata1, k1_par[i] ^ PMASK);
         check_eq($sformatf("k1_par%0d_valid", i), ovalid1, 1'b1);
         check_eq($sformatf("k1_par%0d_par", i), par1, 1'b1);
         check_eq($sformatf("k1_par%0d_last", i), last1, (i == 3));
         check_eq($sformatf("k1_par%0d_ready", i), ready1, (i == 3));
         if (i == 3) valid1 = 1'b0;
         else data1 = 8'($urandom);
      end
      @(negedge clk);
      check_eq("k1_idle_valid", ovalid1, 1'b0);
      check_eq("k1_idle_ready", ready1, 1'b1);

      // K=28: all-zero message, ready low for exactly 4 cycles
      step28(1'b1, 1'b0, 8'h00);
      step28(1'b1, 1'b0, 8'h00);
      lowcnt = 0;
      for (int i = 0; i < K28 + 5; i++) begin
         step28(1'b0, (i < K28), 8'h00);
         if (ready28 === 1'b0) lowcnt++;
      end
      check_eq("zero_msg_ready_low_cycles", lowcnt, 4);

      // 100 random codewords with random gaps and random junk while not ready
      cw_done = 0;
      guard   = 0;
      while (cw_done < 100 && guard < 20000) begin
         step28(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom));
         guard++;
      end
      check_eq("random_codewords_done", cw_done, 100);

      // Back-to-back: byte offered in the o_last cycle comes out with no bubble
      found = 1'b0;
      guard = 0;
      while (!found && guard < 200) begin
         step28(1'b0, 1'b1, 8'($urandom));
         found = exp_last;
         guard++;
      end
      check_eq("b2b_last_reached", found, 1'b1);
      step28(1'b0, 1'b1, 8'h5A);
      check_eq("b2b_next_valid", ovalid28, 1'b1);
      check_eq("b2b_next_par", par28, 1'b0);
      check_eq("b2b_next_data", odata28, 8'h5A);

      // Reset while parity byte 2 is on the output, then a fresh codeword
      step28(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < K28; i++) step28(1'b0, 1'b1, 8'($urandom));
      found = 1'b0;
      guard = 0;
      while (!found && guard < 10) begin
         step28(1'b0, 1'b0, 8'h00);
         found = exp_par && (par_q.size() == 2);
         guard++;
      end
      check_eq("rst_par2_reached", found, 1'b1);
      step28(1'b1, 1'b1, 8'hC3);
      for (int i = 0; i < 6; i++) step28(1'b0, 1'b0, 8'h00);
      cw_done = 0;
      for (int i = 0; i < K28 + 5; i++) step28(1'b0, (i < K28), 8'($urandom));
      check_eq("post_rst_codeword_done", cw_done, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rs_parity_enc.md
RS_PARITY_ENC -- requirements
Module: rs_parity_enc

Interface
REQ-001 SHALL have parameter K, default 28, meaning data bytes per codeword; legal range 1..251; parity count fixed at 4.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_valid  input  1  i_data carries a message byte this cycle.
REQ-005 SHALL have port i_data  input  8  message byte, GF(256) symbol, sent highest-degree coefficient first.
REQ-006 SHALL have port o_ready  output  1  encoder accepts a byte this cycle; a byte is accepted when i_valid & o_ready.
REQ-007 SHALL have port o_valid  output  1  o_data carries a codeword byte.
REQ-008 SHALL have port o_data  output  8  codeword byte, systematic: K data bytes, then 4 parity bytes.
REQ-009 SHALL have port o_par  output  1  high when o_data is a parity byte.
REQ-010 SHALL have port o_last  output  1  high on the 4th parity byte only.

Function
REQ-011 SHALL use GF(256) with primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02, as the codebase decoder does.
REQ-012 SHALL use generator g(x) = (x+1)(x+a)(x+a^2)(x+a^3) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40.
REQ-013 SHALL hold a 4-byte remainder r3..r0; on each accepted byte: fb = i_data ^ r3; r3 <= r2 ^ fb*0x0F; r2 <= r1 ^ fb*0x36; r1 <= r0 ^ fb*0x78; r0 <= fb*0x40 (constant GF multiplies).
REQ-014 SHALL have states DATA and PARITY; DATA: o_ready=1, byte counter counts accepted bytes 0..K-1.
REQ-015 SHALL register each accepted byte onto o_data with o_valid=1, o_par=0, exactly 1 cycle after acceptance.
REQ-016 SHALL, on acceptance of byte K-1, enter PARITY next cycle; o_ready=0 for exactly 4 cycles.
REQ-017 SHALL emit parity r3, r2, r1, r0 on the 4 consecutive cycles immediately following the last data byte output, with o_valid=1 and o_par=1, shifting the remainder.
REQ-018 SHALL assert o_last with the r0 parity byte, return to DATA with remainder cleared and counter 0, and raise o_ready in that same cycle, so a new byte can be accepted back-to-back.
REQ-019 SHALL ignore i_valid/i_data while o_ready=0; no byte is lost or buffered.
REQ-020 SHALL allow arbitrary gaps in i_valid during DATA; o_valid=0 in cycles following a non-accepting cycle, except during parity emission.
REQ-021 SHALL produce, for K=1, an output stream of exactly 5 o_valid cycles per codeword, and K+4 in general.

Reset
REQ-022 SHALL, when i_rst=1 at a clock edge, clear remainder and counters, enter DATA, and drive o_valid=0, o_data=0x00, o_par=0, o_last=0, o_ready=1 from the next cycle.
REQ-023 SHALL discard any partial codeword on reset mid-block or mid-parity; i_valid is ignored in the reset cycle.

Configuration
REQ-024 SHALL support macro RS_ENC_PARITY_INVERT_EN: defined -> each parity byte output is bitwise inverted (CD CIRC convention), remainder arithmetic unchanged; undefined -> parity bytes output uninverted.
REQ-025 SHALL leave data bytes, timing and control outputs identical in both configurations.

Verification
REQ-026 SHALL cover: K=1, reset, send 0x01 -> o_data 0x01, then 0x0F, 0x36, 0x78, 0x40 on consecutive cycles; o_last on 0x40 (0xF0,0xC9,0x87,0xBF with RS_ENC_PARITY_INVERT_EN).
REQ-027 SHALL cover: K=28, all-zero message -> parity 00 00 00 00; o_ready low exactly 4 cycles.
REQ-028 SHALL cover: K=28, 100 random messages with random i_valid gaps -> all 4 syndromes S_j = C(a^j), j=0..3, of each 32-byte codeword equal 0x00 (model check against decoder).
REQ-029 SHALL cover: back-to-back codewords with i_valid held high -> second block's first byte accepted in cycle o_last is asserted, output with no bubble.
REQ-030 SHALL cover: i_rst pulsed during parity byte 2 -> no further parity output, next codeword encodes as from a fresh reset.
REQ-031 SHALL cover: i_valid=1 with changing i_data while o_ready=0 -> parity unaffected, bytes not echoed on o_data.
